// File: rtl/pwm_cfg_if.sv
// Config channel for pwm_multi_hr: period/duty/phase words moved
// with a valid/ready handshake.
interface pwm_cfg_if #(
   parameter int NCH      = 4,
   parameter int PRD_BITS = 14,
   parameter int HRBITS   = 3
);
   localparam int DW = PRD_BITS + HRBITS + 1;

   logic                  cfg_valid;
   logic                  cfg_ready;
   logic [PRD_BITS-1:0]   cfg_prd;
   logic [NCH*DW-1:0]     cfg_duty;
   logic [NCH*DW-1:0]     cfg_phase;

   modport master (
      output cfg_valid, cfg_prd, cfg_duty, cfg_phase,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_prd, cfg_duty, cfg_phase,
      output cfg_ready
   );
endinterface

// File: rtl/pwm_multi_hr.sv
// Multi-channel high-resolution PWM: shared coarse timebase, per-channel
// sub-tick slot words, double-buffered config applied at period boundary.
module pwm_multi_hr #(
   parameter int                  NCH      = 4,
   parameter int                  PRD_BITS = 14,
   parameter int                  HRBITS   = 3,
   parameter logic [PRD_BITS-1:0] PRD_RST  = 14'h200
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   pwm_cfg_if.slave                     cfg,
   output logic [NCH*(1<<HRBITS)-1:0]   pwm_d,
   output logic                         sync_o,
   output logic [PRD_BITS-1:0]          tb_o
);
   localparam int S  = 1 << HRBITS;
   localparam int DW = PRD_BITS + HRBITS + 1;

   logic [PRD_BITS-1:0] tb;
   logic [PRD_BITS-1:0] tb_nxt;
   logic [PRD_BITS-1:0] prd;
   logic [PRD_BITS-1:0] pend_prd;
   logic [NCH*DW-1:0]   duty;
   logic [NCH*DW-1:0]   phase;
   logic [NCH*DW-1:0]   pend_duty;
   logic [NCH*DW-1:0]   pend_phase;
   logic                pend;
   logic                wrap;
   logic                apply;
   logic                accept;
   logic [DW-1:0]       p_cur;
   logic [DW-1:0]       p_new;
   logic [NCH*S-1:0]    word;

   assign p_cur  = (DW'(prd) + DW'(1)) << HRBITS;
   assign p_new  = (DW'(pend_prd) + DW'(1)) << HRBITS;
   assign wrap   = enable && (tb == prd);
   assign apply  = pend && (wrap || !enable);
   assign accept = cfg.cfg_valid && !pend;
   assign tb_nxt = (!enable || tb == prd) ? '0 : tb + PRD_BITS'(1);
   assign tb_o   = tb;

   assign cfg.cfg_ready = !pend;

   // (t - ph) mod P with t, ph < P: one conditional add folds it back.
   function automatic logic slot_hi(
      input logic [DW-1:0] t,
      input logic [DW-1:0] ph,
      input logic [DW-1:0] du,
      input logic [DW-1:0] p
   );
      logic [DW-1:0] d;
      d = t - ph;
      if (t < ph) d = d + p;
      return d < du;
   endfunction

   always_comb begin
      word = '0;
      for (int c = 0; c < NCH; c++) begin
         for (int k = 0; k < S; k++) begin
            word[c*S+k] = slot_hi({1'b0, tb, HRBITS'(k)},
                                  phase[c*DW +: DW],
                                  duty[c*DW +: DW],
                                  p_cur);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tb         <= '0;
         prd        <= PRD_RST;
         duty       <= '0;
         phase      <= '0;
         pend       <= 1'b0;
         pend_prd   <= '0;
         pend_duty  <= '0;
         pend_phase <= '0;
         pwm_d      <= '0;
         sync_o     <= 1'b0;
      end else begin
         tb     <= tb_nxt;
         pwm_d  <= enable ? word : '0;
         sync_o <= enable && (tb == '0);
         if (accept) begin
            pend       <= 1'b1;
            pend_prd   <= cfg.cfg_prd;
            pend_duty  <= cfg.cfg_duty;
            pend_phase <= cfg.cfg_phase;
         end else if (apply) begin
            pend <= 1'b0;
            prd  <= pend_prd;
            duty <= pend_duty;
            // Phase is clipped against the incoming period.
            for (int c = 0; c < NCH; c++) begin
               phase[c*DW +: DW] <= (pend_phase[c*DW +: DW] >= p_new) ?
                                    p_new - DW'(1) :
                                    pend_phase[c*DW +: DW];
            end
         end
      end
   end
endmodule

// File: tb/tb_pwm_multi_hr.sv
// Randomized bench for pwm_multi_hr against an arithmetic reference model,
// plus directed golden words for the period/phase/clipping cases.
module tb_pwm_multi_hr;
   localparam int NCH      = 4;
   localparam int PRD_BITS = 14;
   localparam int HRBITS   = 3;
   localparam int S        = 8;
   localparam int DW       = PRD_BITS + HRBITS + 1;
   localparam int PRD_DEF  = 'h200;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 enable = 1'b0;
   logic [NCH*S-1:0]     pwm_d;
   logic                 sync_o;
   logic [PRD_BITS-1:0]  tb_o;

   pwm_cfg_if #(.NCH(NCH), .PRD_BITS(PRD_BITS), .HRBITS(HRBITS)) cfg();

   pwm_multi_hr #(
      .NCH(NCH), .PRD_BITS(PRD_BITS), .HRBITS(HRBITS), .PRD_RST(14'h200)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .cfg(cfg),
      .pwm_d(pwm_d), .sync_o(sync_o), .tb_o(tb_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int m_tb, m_prd, m_duty[NCH], m_phase[NCH];
   bit m_pend;
   int q_prd, q_duty[NCH], q_phase[NCH];
   logic [NCH*S-1:0] e_pwm;
   bit e_sync;
   int last_tb;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [S-1:0] ref_word(int tbv, int prdv, int du, int ph);
      logic [S-1:0] w;
      int p, t, m;
      p = (prdv + 1) * S;
      for (int k = 0; k < S; k++) begin
         t = tbv * S + k;
         m = ((t - ph) % p + p) % p;
         w[k] = (m < du);
      end
      return w;
   endfunction

   function automatic logic [7:0] gold(int ch, int t);
      case (ch)
         0: return (t <= 1) ? 8'hFF : ((t == 2) ? 8'h0F : 8'h00);
         1: case (t)
               8:       return 8'hC0;
               9, 0:    return 8'hFF;
               1:       return 8'h03;
               default: return 8'h00;
            endcase
         2: return (t == 9) ? 8'h80 : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_reset();
      m_tb = 0;
      m_prd = PRD_DEF;
      m_pend = 0;
      for (int c = 0; c < NCH; c++) begin
         m_duty[c] = 0;
         m_phase[c] = 0;
      end
   endtask

   task automatic step();
      logic [NCH*S-1:0] w;
      bit sy, acc, app;
      int nt, p;
      w = '0;
      if (enable)
         for (int c = 0; c < NCH; c++)
            w[c*S +: S] = ref_word(m_tb, m_prd, m_duty[c], m_phase[c]);
      sy  = enable && (m_tb == 0);
      acc = cfg.cfg_valid && !m_pend;
      app = m_pend && (!enable || m_tb == m_prd);
      nt  = (!enable || m_tb == m_prd) ? 0 : m_tb + 1;
      last_tb = m_tb;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
         e_pwm = '0;
         e_sync = 0;
      end else begin
         e_pwm = w;
         e_sync = sy;
         m_tb = nt;
         if (app) begin
            m_pend = 0;
            m_prd = q_prd;
            p = (q_prd + 1) * S;
            for (int c = 0; c < NCH; c++) begin
               m_duty[c] = q_duty[c];
               m_phase[c] = (q_phase[c] >= p) ? p - 1 : q_phase[c];
            end
         end
         if (acc) begin
            m_pend = 1;
            q_prd = int'(cfg.cfg_prd);
            for (int c = 0; c < NCH; c++) begin
               q_duty[c] = int'(cfg.cfg_duty[c*DW +: DW]);
               q_phase[c] = int'(cfg.cfg_phase[c*DW +: DW]);
            end
         end
      end
      #1;
      chk("pwm_d", pwm_d, e_pwm);
      chk("sync_o", sync_o, e_sync);
      chk("tb_o", tb_o, m_tb);
      chk("cfg_ready", cfg.cfg_ready, !m_pend);
   endtask

   task automatic rand_cfg();
      int pr, p;
      pr = $urandom_range(0, 12);
      p = (pr + 1) * S;
      cfg.cfg_prd = PRD_BITS'(pr);
      for (int c = 0; c < NCH; c++) begin
         cfg.cfg_duty[c*DW +: DW]  = DW'($urandom_range(0, p + 8));
         cfg.cfg_phase[c*DW +: DW] = DW'($urandom_range(0, p + 16));
      end
   endtask

   initial begin
      int n, cnt;
      cfg.cfg_valid = 0;
      cfg.cfg_prd = '0;
      cfg.cfg_duty = '0;
      cfg.cfg_phase = '0;
      model_reset();
      rst_n = 0;
      step();
      step();
      rst_n = 1;
      step();

      // default period: 513 ticks, all channels 0
      enable = 1;
      cnt = 0;
      for (int i = 0; i < 1030; i++) begin
         step();
         if (sync_o) cnt++;
      end
      chk("sync_cnt", cnt, 3);

      // directed load while disabled
      enable = 0;
      step();
      cfg.cfg_prd = 14'd9;
      cfg.cfg_duty = '0;
      cfg.cfg_phase = '0;
      cfg.cfg_duty[0*DW +: DW] = DW'(20);
      cfg.cfg_duty[1*DW +: DW] = DW'(20);
      cfg.cfg_phase[1*DW +: DW] = DW'(70);
      cfg.cfg_duty[2*DW +: DW] = DW'(1);
      cfg.cfg_phase[2*DW +: DW] = DW'(100);
      cfg.cfg_valid = 1;
      step();
      cfg.cfg_valid = 0;
      step();
      enable = 1;
      for (int i = 0; i < 20; i++) begin
         step();
         for (int c = 0; c < NCH; c++)
            chk($sformatf("gold_ch%0d_tb%0d", c, last_tb),
                pwm_d[c*S +: S], gold(c, last_tb));
      end

      // mid-period reconfig to prd=4, duty=45
      n = 0;
      while (m_tb != 3 && n < 20) begin
         step();
         n++;
      end
      cfg.cfg_prd = 14'd4;
      for (int c = 0; c < NCH; c++) begin
         cfg.cfg_duty[c*DW +: DW] = DW'(45);
         cfg.cfg_phase[c*DW +: DW] = '0;
      end
      cfg.cfg_valid = 1;
      step();
      cfg.cfg_valid = 0;
      chk("rdy_low", cfg.cfg_ready, 0);
      n = 0;
      do begin
         step();
         n++;
      end while (!sync_o && n < 20);
      chk("sync_seen", sync_o, 1);
      chk("new_word", pwm_d[7:0], 8'hFF);
      n = 0;
      do begin
         step();
         n++;
      end while (!sync_o && n < 20);
      chk("new_period", n, 5);

      // reset with pending config
      for (int i = 0; i < 2; i++) step();
      cfg.cfg_prd = 14'd7;
      cfg.cfg_valid = 1;
      step();
      cfg.cfg_valid = 0;
      rst_n = 0;
      step();
      chk("rst_pwm", pwm_d, 0);
      chk("rst_ready", cfg.cfg_ready, 1);
      rst_n = 1;
      for (int i = 0; i < 5; i++) step();
      enable = 0;
      step();
      step();
      chk("dis_pwm", pwm_d, 0);
      chk("dis_tb", tb_o, 0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) < 3) enable = ~enable;
         cfg.cfg_valid = ($urandom_range(0, 9) == 0);
         if (cfg.cfg_valid) rand_cfg();
         rst_n = ($urandom_range(0, 999) >= 3);
         step();
      end
      rst_n = 1;
      cfg.cfg_valid = 0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
